// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - iterative shift-and-accumulate multiplier, signed/unsigned, valid/ready
module seq_shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nx;
    logic [2*WIDTH:0]       p;
    logic [2*WIDTH:0]       p_step;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH:0]         sum;
    logic [CW-1:0]          cnt;
    logic                   neg;

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned, so no extra bit is needed.
    always_comb begin
        a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
        sum    = {p[2*WIDTH], p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        p_step = {1'b0, sum, p[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= '0;
            mag_a  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mag_a <= a_mag;
                        p     <= {{(WIDTH+1){1'b0}}, b_mag};
                        cnt   <= CW'(WIDTH-1);
                    end
                end
                CALC: begin
                    p   <= p_step;
                    cnt <= cnt - CW'(1);
                    // The final step's product is taken straight from the step logic.
                    if (cnt == '0) begin
                        result <= neg ? -p_step[2*WIDTH-1:0] : p_step[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - directed and randomised checks of seq_shift_add_mult at WIDTH 32, 8, 2
module tb_seq_shift_add_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic iv32 = 0, ir32, ov32, or32 = 0, is32 = 0, bz32;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] r32;
    logic iv8 = 0, ir8, ov8, or8 = 0, is8 = 0, bz8;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] r8;
    logic iv2 = 0, ir2, ov2, or2 = 0, is2 = 0, bz2;
    logic [1:0] a2 = '0, b2 = '0;
    logic [3:0] r2;

    seq_shift_add_mult #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .is_signed(is32), .out_valid(ov32), .out_ready(or32), .result(r32), .busy(bz32));
    seq_shift_add_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(is8), .out_valid(ov8), .out_ready(or8), .result(r8), .busy(bz8));
    seq_shift_add_mult #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .is_signed(is2), .out_valid(ov2), .out_ready(or2), .result(r2), .busy(bz2));

    int n_tests = 0;
    int n_fail  = 0;
    int ops32 = 0, ops8 = 0, ops2 = 0;
    int hs32 = 0, hs8 = 0, hs2 = 0;

    always @(posedge clk) begin
        if (ov32 && or32) hs32 <= hs32 + 1;
        if (ov8 && or8)   hs8  <= hs8 + 1;
        if (ov2 && or2)   hs2  <= hs2 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input int w, input logic v, input logic s, input logic [31:0] av, input logic [31:0] bv);
        case (w)
            32: begin iv32 = v; is32 = s; a32 = av; b32 = bv; end
            8:  begin iv8 = v; is8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
            default: begin iv2 = v; is2 = s; a2 = av[1:0]; b2 = bv[1:0]; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic v);
        case (w)
            32: or32 = v;
            8:  or8 = v;
            default: or2 = v;
        endcase
    endtask

    function automatic logic get_ov(input int w);
        return (w == 32) ? ov32 : (w == 8) ? ov8 : ov2;
    endfunction
    function automatic logic get_ir(input int w);
        return (w == 32) ? ir32 : (w == 8) ? ir8 : ir2;
    endfunction
    function automatic logic get_bz(input int w);
        return (w == 32) ? bz32 : (w == 8) ? bz8 : bz2;
    endfunction
    function automatic logic [63:0] get_res(input int w);
        return (w == 32) ? r32 : (w == 8) ? {48'd0, r8} : {60'd0, r2};
    endfunction

    function automatic logic [63:0] model(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb;
        logic [63:0] p, m;
        sa = longint'(av);
        sb = longint'(bv);
        if (s && av[w-1]) sa = sa - (longint'(1) << w);
        if (s && bv[w-1]) sb = sb - (longint'(1) << w);
        p = 64'(sa * sb);
        m = (w == 32) ? {64{1'b1}} : ((64'd1 << (2*w)) - 64'd1);
        return p & m;
    endfunction

    // Called #1 after a rising edge; returns #1 after the output handshake edge.
    task automatic run_op(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input int stall, input logic poke, input logic [63:0] exp, input string tag);
        int lat;
        drive_in(w, 1'b1, s, av, bv);
        @(posedge clk); #1;
        check({tag, " busy"}, 64'(get_bz(w)), 64'd1);
        drive_in(w, 1'b0, ~s, ~av, ~bv);
        lat = 0;
        while (!get_ov(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(w));
        check({tag, " result"}, get_res(w), exp);
        for (int i = 0; i < stall; i++) begin
            if (poke) drive_in(w, 1'b1, s, bv, av);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(get_ov(w)), 64'd1);
            check({tag, " hold result"}, get_res(w), exp);
            if (poke) check({tag, " in_ready"}, 64'(get_ir(w)), 64'd0);
        end
        drive_in(w, 1'b0, s, av, bv);
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check({tag, " valid drop"}, 64'(get_ov(w)), 64'd0);
        case (w)
            32: ops32++;
            8:  ops8++;
            default: ops2++;
        endcase
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        logic rs;
        int ws[3];
        int nops[3];
        ws = '{32, 8, 2};
        nops = '{200, 1000, 2000};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(ir32), 64'd1);
        check("reset out_valid", 64'(ov32), 64'd0);
        check("reset busy", 64'(bz32), 64'd0);
        check("reset result", r32, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 64'hFFFFFFFE00000001, "u max");
        run_op(32, 1'b1, 32'h80000000, 32'h80000000, 0, 1'b0, 64'h4000000000000000, "s minneg");
        run_op(32, 1'b1, 32'hFFFFFFFD, 32'd7, 1, 1'b0, 64'hFFFFFFFFFFFFFFEB, "s -3x7");
        run_op(32, 1'b0, 32'hFFFFFFFD, 32'd7, 0, 1'b0, 64'h00000006FFFFFFEB, "u -3x7");
        run_op(32, 1'b0, 32'd0, 32'h12345678, 0, 1'b0, 64'd0, "u zero");
        run_op(8, 1'b1, 32'h80, 32'h7F, 5, 1'b1, 64'hC080, "w8 backpressure");
        check("w8 no extra accept", 64'(bz8), 64'd0);
        run_op(8, 1'b1, 32'h80, 32'h80, 0, 1'b0, 64'h4000, "w8 minneg sq");
        run_op(2, 1'b1, 32'h2, 32'h2, 0, 1'b0, 64'h4, "w2 s -2x-2");
        run_op(2, 1'b0, 32'h3, 32'h3, 0, 1'b0, 64'h9, "w2 u 3x3");
        run_op(2, 1'b1, 32'h3, 32'h1, 0, 1'b0, 64'hF, "w2 s -1x1");

        // Asynchronous reset in the middle of a 32-bit operation.
        drive_in(32, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678);
        @(posedge clk); #1;
        drive_in(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(ir32), 64'd1);
        check("abort out_valid", 64'(ov32), 64'd0);
        check("abort busy", 64'(bz32), 64'd0);
        check("abort result", r32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) pulses++;
        end
        check("abort no out_valid", 64'(pulses), 64'd0);
        run_op(32, 1'b0, 32'd3, 32'd5, 0, 1'b0, 64'd15, "after abort 3x5");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nops[k]; i++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                if (ws[k] < 32) begin
                    ra = ra & ((32'd1 << ws[k]) - 32'd1);
                    rb = rb & ((32'd1 << ws[k]) - 32'd1);
                end
                if (i % 50 == 0) ra = 32'd1 << (ws[k] - 1);
                run_op(ws[k], rs, ra, rb, $urandom_range(0, 3), 1'b0, model(ws[k], rs, ra, rb), "random");
            end
        end

        @(posedge clk); #1;
        check("w32 handshake count", 64'(hs32), 64'(ops32));
        check("w8 handshake count", 64'(hs8), 64'(ops8));
        check("w2 handshake count", 64'(hs2), 64'(ops2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
